// File: rtl/serial_adder_4_bit.sv
// serial_adder_4_bit: bit-serial ripple adder, one full-adder step per clock.
// A start in IDLE captures the operands and carry-in. RUN then processes
// WIDTH bits, LSB first. DONE presents {c_out_r, sum_r} until out_ready.
module serial_adder_4_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum_r,
    output logic             c_out_r
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // Next-state decode and the single 1-bit full adder
    always_comb begin
        state_next = state;
        fa_s       = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c       = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last_bit   = (cnt == LAST_BIT);
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // State, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            sum_r     <= '0;
            c_out_r   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == RUN);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter the A register at its MSB as operand bits leave
                    // at the LSB, so after WIDTH steps A holds the whole sum.
                    a_sh  <= {fa_s, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_r   <= {fa_s, a_sh[WIDTH-1:1]};
                        c_out_r <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_4_bit.sv
// tb_serial_adder_4_bit: directed and random checks of serial_adder_4_bit.
// A scoreboard queue holds the expected {carry, sum} for each accepted start.
module tb_serial_adder_4_bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] sum_r;
    logic         c_out_r;

    logic [W:0]   sb_q[$];
    logic [W:0]   last_res = '0;
    int           n_tests = 0;
    int           n_fail = 0;

    serial_adder_4_bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .sum_r     (sum_r),
        .c_out_r   (c_out_r)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled at negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scramble_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
    endtask

    // Present a start for one edge from IDLE and record the expected result
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        sb_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv});
        tick();
        start = 1'b0;
        scramble_inputs();
    endtask

    // Cycle-exact check of the RUN window, starting at the negedge after acceptance
    task automatic run_phase();
        for (int i = 0; i < W; i++) begin
            chk("busy_run", busy, 1);
            chk("valid_run", out_valid, 0);
            chk("hold_run", {c_out_r, sum_r}, last_res);
            out_ready = 1'($urandom);
            scramble_inputs();
            tick();
        end
        out_ready = 1'b0;
        chk("valid_latency", out_valid, 1);
        chk("busy_done", busy, 0);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
        if (!out_valid) chk("valid_timeout", out_valid, 1);
    endtask

    task automatic check_result();
        logic [W:0] e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk("result", {c_out_r, sum_r}, e);
            last_res = e;
        end
    endtask

    // Stall for some cycles with noisy inputs, then retire with start held high
    task automatic retire(input int stall);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            scramble_inputs();
            tick();
            chk("valid_stall", out_valid, 1);
            chk("busy_stall", busy, 0);
            chk("hold_stall", {c_out_r, sum_r}, last_res);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("valid_retired", out_valid, 0);
        chk("busy_retire_start", busy, 0);
        chk("hold_idle", {c_out_r, sum_r}, last_res);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", {c_out_r, sum_r}, 0);

        // out_ready while idle has no effect
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_ready_busy", busy, 0);
        chk("idle_ready_valid", out_valid, 0);

        // 3 + 5 with exact latency
        launch(4'h3, 4'h5, 1'b0);
        run_phase();
        check_result();
        retire(0);

        // Carry-out cases
        launch(4'hF, 4'h1, 1'b0);
        run_phase();
        check_result();
        retire(1);
        launch(4'hF, 4'hF, 1'b1);
        run_phase();
        check_result();

        // Stall 3 cycles with start/operands toggling, start on retire edge ignored
        retire(3);
        tick();
        chk("idle_after_retire", busy, 0);

        // start during RUN is ignored
        launch(4'h6, 4'h7, 1'b0);
        tick();
        start = 1'b1;
        a     = 4'h1;
        b     = 4'h1;
        tick();
        start = 1'b0;
        wait_valid(2 * W + 4);
        check_result();
        retire(0);

        // Reset mid-RUN wins over start/out_ready and discards the operation
        launch(4'h9, 4'h3, 1'b1);
        tick();
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("rst_run_busy", busy, 0);
        chk("rst_run_valid", out_valid, 0);
        chk("rst_run_result", {c_out_r, sum_r}, 0);
        sb_q.delete();
        last_res = '0;
        launch(4'h2, 4'h2, 1'b0);
        run_phase();
        check_result();

        // Reset while in DONE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_done_valid", out_valid, 0);
        chk("rst_done_result", {c_out_r, sum_r}, 0);
        last_res = '0;

        // Random back-to-back operations with random stalls
        for (int k = 0; k < 200; k++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom));
            wait_valid(2 * W + 4);
            check_result();
            retire(int'($urandom_range(0, 3)));
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_4_bit.md
SERIAL_ADDER_4_BIT -- requirements
Module: serial_adder_4_bit

Interface
REQ-001 Parameter WIDTH: default 4; operand and result width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port clk: input, 1 bit, single clock; all state SHALL update on the posedge only.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset, sampled on the clk posedge.
REQ-004 Port start: input, 1 bit, request to begin an addition; the block SHALL sample it only in IDLE.
REQ-005 Port a: input, WIDTH bits, operand A, captured when start is accepted.
REQ-006 Port b: input, WIDTH bits, operand B, captured when start is accepted.
REQ-007 Port cin: input, 1 bit, carry-in, captured when start is accepted.
REQ-008 Port out_ready: input, 1 bit, downstream consumer acknowledges the result.
REQ-009 Port busy: output, 1 bit, registered, high while in RUN.
REQ-010 Port out_valid: output, 1 bit, registered, high while in DONE.
REQ-011 Port sum_r: output, WIDTH bits, registered sum, fed directly to the downstream 4-bit mux stage.
REQ-012 Port c_out_r: output, 1 bit, registered final carry-out.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE; IDLE is the encoding after reset.
REQ-014 In IDLE, start=1 at a posedge SHALL load a and b into shift registers, load cin into the carry register, clear the bit counter and move to RUN.
REQ-015 In RUN, each posedge SHALL compute one bit LSB-first using a single 1-bit full adder: s = a0^b0^c; c' = (a0&b0)|(c&(a0^b0)).
REQ-016 Each RUN posedge SHALL shift s into the result register MSB end, shift both operands right by one bit, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH posedges; on the WIDTH-th posedge the state SHALL move to DONE and sum_r/c_out_r SHALL take the final result.
REQ-018 Latency: with start accepted at edge E0, out_valid SHALL first be high after edge E(WIDTH), i.e. 4 edges later for WIDTH=4.
REQ-019 sum_r and c_out_r SHALL change only on entry to DONE and SHALL hold otherwise, including throughout RUN and after return to IDLE.
REQ-020 In DONE, out_valid SHALL stay high and the outputs SHALL stay stable until a posedge with out_ready=1; that edge SHALL move the state to IDLE.
REQ-021 start SHALL be ignored in RUN and in DONE, including the cycle in which out_ready retires the result; the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-022 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-023 out_ready outside DONE SHALL have no effect.
REQ-024 The result SHALL equal a+b+cin modulo 2^(WIDTH+1), split as {c_out_r, sum_r}.

Reset
REQ-025 rst=1 at a posedge SHALL force state IDLE and clear busy, out_valid, sum_r, c_out_r, the operand shift registers, the carry register and the counter, in any state.
REQ-026 rst SHALL take priority over start and out_ready in the same cycle.
REQ-027 A reset during RUN or DONE SHALL discard the operation, and the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-028 a=4'h3, b=4'h5, cin=0, start pulse -> busy high for 4 cycles; out_valid high 4 edges after acceptance; sum_r=4'h8, c_out_r=0.
REQ-029 a=4'hF, b=4'h1, cin=0 -> sum_r=4'h0, c_out_r=1; a=4'hF, b=4'hF, cin=1 -> sum_r=4'hF, c_out_r=1.
REQ-030 Result ready, out_ready held low 3 cycles while start pulses and a/b toggle -> out_valid and outputs stable; one out_ready cycle -> IDLE next edge, start on that same edge ignored.
REQ-031 Start a=4'h6, b=4'h7; on the 2nd RUN cycle drive start=1 with a=4'h1, b=4'h1 -> result sum_r=4'hD, c_out_r=0.
REQ-032 rst asserted on the 2nd RUN cycle -> next edge busy=0, out_valid=0, sum_r=0, c_out_r=0; then start with a=4'h2, b=4'h2 -> sum_r=4'h4.
REQ-033 Back-to-back: 200 random operand/cin sets with random out_ready stalls, checked against a+b+cin -> zero mismatches.
